// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared defaults and FSM encodings for the fifo_wr_arb slice.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int c_DW_DEF    = 8;
  localparam int c_BURST_DEF = 4;

  typedef logic [1:0] state_t;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_GRANT = 2'd1;
  localparam logic [1:0] c_STALL = 2'd2;

  // True when the write about to happen is the final one of the grant.
  function automatic logic burst_last(input logic [3:0] cnt, input logic [3:0] limit);
    return (cnt + 4'd1) == limit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arb_if
// Brief    : Requester / FIFO-write handshake bundle for fifo_wr_arb.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_wr_arb_if import fifo_pkg::*; #(
  parameter int DW = c_DW_DEF
) ();

  logic          req0;
  logic          req1;
  logic [DW-1:0] din0;
  logic [DW-1:0] din1;
  logic          ack0;
  logic          ack1;
  logic          fifo_full;
  logic          wr_en;
  logic [DW-1:0] dout;
  logic          gnt_id;
  logic          busy;

  modport slave (
    input  req0, req1, din0, din1, fifo_full,
    output ack0, ack1, wr_en, dout, gnt_id, busy
  );

  modport master (
    output req0, req1, din0, din1, fifo_full,
    input  ack0, ack1, wr_en, dout, gnt_id, busy
  );

endinterface
`default_nettype wire

// File: rtl/fifo_wr_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational 2-way round-robin selector; rr names the favoured side.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick import fifo_pkg::*; (
  input  logic req0,
  input  logic req1,
  input  logic rr,
  output logic owner,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    owner = rr ? req1 : ~req0;
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arb
// Brief    : Two-requester burst arbiter feeding a FIFO write port, one word
//            per two cycles. Optional ACK counters via FIFO_WR_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arb import fifo_pkg::*; #(
  parameter int DW    = c_DW_DEF,
  parameter int BURST = c_BURST_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  fifo_wr_arb_if.slave  bus
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [7:0]    cnt0,
  output logic [7:0]    cnt1
`endif
);

  localparam logic [3:0] c_BURST = 4'(BURST);

  state_t        r_state;
  logic          r_rr;
  logic          r_owner;
  logic [3:0]    r_burst;
  logic          r_wr_en;
  logic          r_ack0;
  logic          r_ack1;
  logic [DW-1:0] r_dout;

  logic          w_pick_owner;
  logic          w_pick_valid;
  logic          w_req_own;
  logic [DW-1:0] w_din_own;
  logic          w_write;
  logic          w_last;

  rr_pick u_rr_pick (
    .req0  (bus.req0),
    .req1  (bus.req1),
    .rr    (r_rr),
    .owner (w_pick_owner),
    .valid (w_pick_valid)
  );

  // Gating on r_wr_en enforces a dead cycle after every write, so the
  // FIFO_FULL sampled here always reflects the previous word.
  always_comb begin
    w_req_own = r_owner ? bus.req1 : bus.req0;
    w_din_own = r_owner ? bus.din1 : bus.din0;
    w_write   = (r_state == c_GRANT) && w_req_own && !bus.fifo_full && !r_wr_en;
    w_last    = burst_last(r_burst, c_BURST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_rr    <= 1'b0;
      r_owner <= 1'b0;
      r_burst <= 4'd0;
      r_wr_en <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_wr_en <= w_write;
      r_ack0  <= w_write && !r_owner;
      r_ack1  <= w_write &&  r_owner;
      if (w_write) begin
        r_dout <= w_din_own;
      end

      case (r_state)
        c_IDLE: begin
          if (w_pick_valid) begin
            r_owner <= w_pick_owner;
            r_burst <= 4'd0;
            r_state <= c_GRANT;
          end
        end
        c_GRANT: begin
          if (!w_req_own) begin
            r_rr    <= ~r_owner;
            r_state <= c_IDLE;
          end else if (bus.fifo_full) begin
            r_state <= c_STALL;
          end else if (w_write) begin
            r_burst <= r_burst + 4'd1;
            if (w_last) begin
              r_rr    <= ~r_owner;
              r_state <= c_IDLE;
            end
          end
        end
        c_STALL: begin
          if (!w_req_own) begin
            r_state <= c_IDLE;
          end else if (!bus.fifo_full) begin
            r_state <= c_GRANT;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.wr_en  = r_wr_en;
  assign bus.ack0   = r_ack0;
  assign bus.ack1   = r_ack1;
  assign bus.dout   = r_dout;
  assign bus.gnt_id = r_owner;
  assign bus.busy   = (r_state != c_IDLE);

`ifdef FIFO_WR_ARB_STATS_EN
  logic [7:0] r_cnt0;
  logic [7:0] r_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= 8'd0;
      r_cnt1 <= 8'd0;
    end else begin
      if (r_ack0) r_cnt0 <= r_cnt0 + 8'd1;
      if (r_ack1) r_cnt1 <= r_cnt1 + 8'd1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arb
// Brief    : Scoreboard bench for fifo_wr_arb (define FIFO_WR_ARB_STATS_EN for counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arb;

  logic clk;
  logic rst_n;

  fifo_wr_arb_if #(.DW(8)) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
  logic [7:0] cnt0;
  logic [7:0] cnt1;
`endif

  fifo_wr_arb #(.DW(8), .BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .cnt0  (cnt0),
    .cnt1  (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         n_wr  = 0;
  bit         mon_en = 1'b0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic id, input logic [7:0] d);
    exp_q.push_back({id, d});
    if (id) q1.push_back(d);
    else    q0.push_back(d);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_timeout"}, 32'(t >= 3000), 32'd0);
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    exp_q.delete();
    bus.fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Requester model: present the queue head, advance it on each ACK.
  initial begin
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.din0 = 8'h00;
    bus.din1 = 8'h00;
    bus.fifo_full = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ack0 === 1'b1 && q0.size() != 0) void'(q0.pop_front());
      if (bus.ack1 === 1'b1 && q1.size() != 0) void'(q1.pop_front());
      bus.req0 = (q0.size() != 0);
      bus.req1 = (q1.size() != 0);
      if (q0.size() != 0) bus.din0 = q0[0];
      if (q1.size() != 0) bus.din1 = q1[0];
    end
  end

  // Monitor: every write is matched against the scoreboard head.
  initial begin
    logic       prev_wr;
    logic [8:0] e;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en || rst_n !== 1'b1) begin
        prev_wr = 1'b0;
      end else begin
        if (bus.wr_en === 1'b1) begin
          n_wr++;
          n_vec++;
          if (prev_wr) begin
            n_err++;
            $display("FAIL spacing: wr_en high on two consecutive cycles, required a gap");
          end
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write: ack1=%0b ack0=%0b dout=%02h, expected no write",
                     bus.ack1, bus.ack0, bus.dout);
          end else begin
            e = exp_q.pop_front();
            if ({bus.ack1, bus.ack0, bus.gnt_id, bus.dout} !== {e[8], ~e[8], e[8], e[7:0]}) begin
              n_err++;
              $display("FAIL write: got ack1=%0b ack0=%0b gnt=%0b dout=%02h, expected id=%0b dout=%02h",
                       bus.ack1, bus.ack0, bus.gnt_id, bus.dout, e[8], e[7:0]);
            end
          end
        end else if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin
          n_vec++;
          n_err++;
          $display("FAIL stray_ack: ack0=%0b ack1=%0b with wr_en=0, expected 0", bus.ack0, bus.ack1);
        end
        prev_wr = (bus.wr_en === 1'b1);
      end
    end
  end

  initial begin
    int base;
    int t;
    rst_n = 1'b1;

    // Reset state
    #6  rst_n = 1'b0;
    #10 rst_n = 1'b1;
    #2;
    check("rst_wr_en",  32'(bus.wr_en),  32'd0);
    check("rst_ack0",   32'(bus.ack0),   32'd0);
    check("rst_ack1",   32'(bus.ack1),   32'd0);
    check("rst_dout",   32'(bus.dout),   32'd0);
    check("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
    check("rst_busy",   32'(bus.busy),   32'd0);
`ifdef FIFO_WR_ARB_STATS_EN
    check("rst_cnt0", 32'(cnt0), 32'd0);
    check("rst_cnt1", 32'(cnt1), 32'd0);
`endif
    mon_en = 1'b1;

    // Single requester, six words across two grants
    for (int i = 0; i < 6; i++) push(1'b0, 8'(i));
    drain("single");
    check("single_busy_idle", 32'(bus.busy),   32'd0);
    check("single_gnt_id",    32'(bus.gnt_id), 32'd0);

    // Contention from IDLE with RR=0
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'h10 + 8'(i)});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 8'h20 + 8'(i)});
    for (int i = 4; i < 8; i++) exp_q.push_back({1'b0, 8'h10 + 8'(i)});
    for (int i = 4; i < 8; i++) exp_q.push_back({1'b1, 8'h20 + 8'(i)});
    for (int i = 0; i < 8; i++) begin
      q0.push_back(8'h10 + 8'(i));
      q1.push_back(8'h20 + 8'(i));
    end
    drain("contention");
    check("contention_gnt_id", 32'(bus.gnt_id), 32'd1);
    check("contention_busy",   32'(bus.busy),   32'd0);

    // FIFO full after word 2 of an owner-0 burst
    do_reset();
    base = n_wr;
    for (int i = 0; i < 4; i++) push(1'b0, 8'h30 + 8'(i));
    t = 0;
    while (n_wr < base + 2 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("full_reach_word2", 32'(n_wr - base), 32'd2);
    bus.fifo_full = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("full_no_write",  32'(n_wr - base), 32'd2);
    check("full_busy",      32'(bus.busy),    32'd1);
    check("full_wr_en_low", 32'(bus.wr_en),   32'd0);
    bus.fifo_full = 1'b0;
    drain("full");
    check("full_words", 32'(n_wr - base), 32'd4);
    check("full_busy_released", 32'(bus.busy), 32'd0);

    // Reset mid-grant with 0xA5 pending; RR must come back as 0
    do_reset();
    push(1'b0, 8'h40);
    drain("pre_mid_reset");
    base = n_wr;
    q0.push_back(8'hA5);
    t = 0;
    while (bus.busy !== 1'b1 && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("mid_granted", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    q0.delete();
    #1;
    check("mid_wr_en",  32'(bus.wr_en),  32'd0);
    check("mid_ack0",   32'(bus.ack0),   32'd0);
    check("mid_busy",   32'(bus.busy),   32'd0);
    check("mid_gnt_id", 32'(bus.gnt_id), 32'd0);
    check("mid_dout",   32'(bus.dout),   32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("mid_no_write", 32'(n_wr - base), 32'd0);
    push(1'b0, 8'hA5);
    push(1'b1, 8'hB6);
    drain("post_mid_reset");

`ifdef FIFO_WR_ARB_STATS_EN
    // 256 acknowledgements to requester 1 wrap its counter to zero
    do_reset();
    for (int i = 0; i < 256; i++) push(1'b1, 8'(i));
    drain("stats");
    check("stats_cnt1_wrap", 32'(cnt1), 32'd0);
    check("stats_cnt0",      32'(cnt0), 32'd0);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter DW, default 8: data width of requester words and the FIFO write port.
REQ-002 Parameter BURST, default 4: maximum words written per grant before priority rotates; legal range 1..15.
REQ-003 Port CLK  input  1: single clock; all state updates on the rising edge.
REQ-004 Port RST  input  1: asynchronous, active-low reset.
REQ-005 Ports REQ0, REQ1  input  1 each: requester n has a word pending.
REQ-006 Ports DIN0, DIN1  input  DW each: requester n word; held stable while REQn=1 and ACKn=0.
REQ-007 Ports ACK0, ACK1  output  1 each: one-cycle pulse, requester n's word was written this cycle.
REQ-008 Port FIFO_FULL  input  1: the FIFO's Full flag.
REQ-009 Port WR_EN  output  1: FIFO write strobe.
REQ-010 Port DOUT  output  DW: FIFO write data (FIFO Din).
REQ-011 Port GNT_ID  output  1: current or last owner (0/1).
REQ-012 Port BUSY  output  1: high while state is not IDLE.

Function
REQ-013 FSM states IDLE, GRANT, STALL; encoding from the shared package.
REQ-014 IDLE: if any REQn=1, select owner by round-robin pointer RR (RR requester wins if requesting, else the other), load owner, clear burst count, go GRANT.
REQ-015 GRANT: on an edge where REQ_owner=1, FIFO_FULL=0 and WR_EN was 0 in the current cycle, register WR_EN=1, DOUT=DIN_owner, ACK_owner=1 for exactly the next cycle; increment burst count.
REQ-016 Write spacing: never two consecutive WR_EN cycles; max throughput one word per two cycles, so FIFO_FULL is always current.
REQ-017 GRANT with FIFO_FULL=1 and REQ_owner=1: go STALL; no WR_EN, no ACK.
REQ-018 STALL: return to GRANT when FIFO_FULL=0; go IDLE if REQ_owner drops; burst count held.
REQ-019 Grant release: after BURST writes, or REQ_owner=0 in GRANT: RR := ~owner, go IDLE; a write and release may coincide on the same edge.
REQ-020 Non-owner REQ is ignored until release; ACK0 and ACK1 never high together; ACKn only when WR_EN=1.
REQ-021 DOUT holds the last written word when WR_EN=0.
REQ-022 Both requests arriving in IDLE on the same edge: RR decides; the loser is served next.

Reset
REQ-023 RST=0 forces, asynchronously: state IDLE, RR=0, owner 0, burst count 0, WR_EN=0, ACK0=ACK1=0, DOUT=0, GNT_ID=0, BUSY=0.
REQ-024 Reset mid-burst drops the grant; a word pending at reset is not written and not acknowledged; the requester must re-present it.

Configuration
REQ-025 Macro FIFO_WR_ARB_STATS_EN: when defined, adds outputs CNT0, CNT1 (8 bits each), counting ACK0/ACK1 pulses, wrapping 255->0, reset to 0; when undefined, the ports and logic are absent and the remaining behaviour is identical.

Structure
REQ-026 Shared package fifo_pkg holds DW default, the FSM state typedef and encodings, and the BURST default.
REQ-027 One sub-module, rr_pick: combinational 2-way round-robin selector (REQ0, REQ1, RR -> owner, valid).

Verification
REQ-028 Reset: RST low at 6 ns, high at 16 ns -> all outputs 0; BUSY=0.
REQ-029 Single requester: REQ0=1, DIN0=0x00..0x05 advanced on each ACK0 -> WR_EN pulses on alternate cycles, DOUT 0x00..0x05, grant released after 4 words, re-granted to 0 since REQ1=0.
REQ-030 Contention: REQ0=REQ1=1 from IDLE, RR=0 -> 4 words from requester 0, then 4 from requester 1, alternating; ACKs never overlap.
REQ-031 Full: FIFO_FULL=1 during owner-0 burst after word 2 -> STALL, no WR_EN; FIFO_FULL=0 -> words 3 and 4 written, then release.
REQ-032 Reset mid-burst: RST low while GRANT with DIN0=0xA5 pending -> no ACK0, WR_EN=0, state IDLE, RR=0.
REQ-033 With FIFO_WR_ARB_STATS_EN: 256 writes from requester 1 -> CNT1 wraps to 0, CNT0=0.
